bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Two-requester arbiter and sequencer for the single-port 2^18 x 8 image BRAM. It shares the single BRAM port between a write stream and a read-request stream. The write stream is the image loader filling the frame. The read-request stream is the median-filter window fetcher. Arbitration is bounded-burst round-robin, and the block returns read data with a one-cycle valid strobe aligned to the BRAM's registered output.

## Interface
- ADDR_WIDTH, 18, BRAM address width
- BIT_WIDTH, 8, pixel/data width
- BURST_LEN, 4, max consecutive beats granted to one requester while the other is waiting (>=1)

- clka  in  1  clock, shared with BRAM; one clock, everything on rising edge
- rsta_n  in  1  reset, synchronous, active-low
- w_valid  in  1  write request valid
- w_ready  out  1  write beat accepted when w_valid & w_ready
- w_addr  in  ADDR_WIDTH  write address
- w_data  in  BIT_WIDTH  write data
- r_valid  in  1  read request valid
- r_ready  out  1  read beat accepted when r_valid & r_ready
- r_addr  in  ADDR_WIDTH  read address
- r_dvalid  out  1  read data valid, exactly one per accepted read
- r_data  out  BIT_WIDTH  read data, meaningful only when r_dvalid
- bram_ena  out  1  BRAM enable
- bram_wea  out  1  BRAM write enable
- bram_addra  out  ADDR_WIDTH  BRAM address
- bram_dina  out  BIT_WIDTH  BRAM write data
- bram_douta  in  BIT_WIDTH  BRAM registered read data

## Operation
- State machine: IDLE, GNT_W, GNT_R. The block also holds the registers last_owner (W/R) and beat_cnt (clog2(BURST_LEN) bits).
- IDLE: w_ready=r_ready=0, no BRAM access.
  - Both valid -> go to the requester != last_owner.
  - One valid -> go to that requester.
  - Neither valid -> stay in IDLE.
- GNT_W: w_ready=1, r_ready=0. GNT_R: r_ready=1, w_ready=0.
- A beat is owner_valid & owner_ready. On each beat beat_cnt increments.
- Leave the grant state for IDLE (setting last_owner=owner and beat_cnt=0) when either condition holds:
  - owner_valid=0, or
  - a beat occurs with beat_cnt==BURST_LEN-1 and the other requester is valid.
- Beat at beat_cnt==BURST_LEN-1 with the other requester idle: beat_cnt wraps to 0, stay in the grant state (unbounded streaming when uncontended).
- BRAM drive (combinational from state and valids):
  - bram_ena = write beat | read beat.
  - bram_wea = write beat.
  - bram_addra = w_addr in GNT_W, else r_addr.
  - bram_dina = w_data.
- Read response: r_dvalid is registered = read beat of the previous cycle. r_data = bram_douta (pass-through). There is no backpressure on responses; the consumer must take them.
- Requesters must hold addr/data stable while valid and not ready.
- Reset (rsta_n=0 at an edge):
  - state=IDLE, last_owner=R (so W wins the first tie), beat_cnt=0, r_dvalid=0.
  - All outputs are low while in IDLE.
- Reset mid-burst: the pending read response is dropped (r_dvalid=0 the following cycle). A write beat accepted before the reset edge has completed.

## Timing
- Arbitration handoff costs exactly one IDLE cycle. Fresh request from IDLE: valid seen in cycle N, ready=1 in N+1.
- Read latency: a read beat in cycle N gives r_dvalid=1 and r_data valid in N+1.
- Write beat in cycle N updates memory at the end of N. A read of the same address accepted in cycle >= N+1 returns the new data. A one-cycle W->R handoff guarantees this.
- Contended steady state: BURST_LEN beats W, 1 idle, BURST_LEN beats R, 1 idle, repeating. Throughput is BURST_LEN/(BURST_LEN+1).
- Addresses are used unmodified. Address 2^ADDR_WIDTH-1 is legal; there is no internal wrap or increment.

## Test plan
- Reset: hold rsta_n=0 with w_valid=r_valid=1.
  - Required: w_ready, r_ready, bram_ena and r_dvalid all 0.
  - After release: w_ready=1 one cycle later (W wins the first tie).
- Write burst then readback: write addr 0..3 with data 0x10..0x13.
  - Then read addr 0..3 back: r_dvalid pulses for 4 cycles, one cycle after each read beat, with r_data 0x10..0x13 in order.
- Contention with BURST_LEN=4: w_valid and r_valid both held high.
  - Required grant pattern: 4 W beats, 1 idle, 4 R beats, 1 idle, repeating.
  - No read response is missing or duplicated.
- Early release: W granted, w_valid drops after 2 beats while r_valid=1.
  - Required: IDLE next cycle, then GNT_R.
  - beat_cnt restarts at 0.
- Reset mid-read: assert rsta_n=0 in the cycle of a read beat.
  - Required: r_dvalid=0 in the next cycle, state IDLE, r_ready=0.
- Boundary address: write 0xA5 to addr 0x3FFFF, then read it.
  - Required: bram_addra=0x3FFFF on both beats, r_data=0xA5.
  - Uncontended 10-beat write stream runs with no idle cycles (beat_cnt wraps).

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Shares one single-port image BRAM between the loader write stream and the window-fetch
// read stream. Arbitration is bounded-burst round-robin with a one-cycle idle at each handoff.
module bram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned BIT_WIDTH  = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [BIT_WIDTH-1:0]  w_data,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_dvalid,
  output logic [BIT_WIDTH-1:0]  r_data,
  output logic                  bram_ena,
  output logic                  bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [BIT_WIDTH-1:0]  bram_dina,
  input  logic [BIT_WIDTH-1:0]  bram_douta
);

  localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StGntW, StGntR} state_e;

  state_e          state_q, state_d;
  logic            last_r_q, last_r_d;  // 1: read port owned the most recent grant
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic            r_dvalid_q;
  logic            w_beat, r_beat;

  always_comb begin
    state_d    = state_q;
    last_r_d   = last_r_q;
    beat_cnt_d = beat_cnt_q;
    w_ready    = 1'b0;
    r_ready    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (w_valid && r_valid) begin
          state_d = last_r_q ? StGntW : StGntR;
        end else if (w_valid) begin
          state_d = StGntW;
        end else if (r_valid) begin
          state_d = StGntR;
        end
      end
      StGntW: begin
        w_ready = 1'b1;
        if (!w_valid) begin
          state_d    = StIdle;
          last_r_d   = 1'b0;
          beat_cnt_d = '0;
        end else if (beat_cnt_q == CntLast) begin
          // Wrap keeps an uncontended stream going without an idle slot.
          beat_cnt_d = '0;
          if (r_valid) begin
            state_d  = StIdle;
            last_r_d = 1'b0;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      StGntR: begin
        r_ready = 1'b1;
        if (!r_valid) begin
          state_d    = StIdle;
          last_r_d   = 1'b1;
          beat_cnt_d = '0;
        end else if (beat_cnt_q == CntLast) begin
          beat_cnt_d = '0;
          if (w_valid) begin
            state_d  = StIdle;
            last_r_d = 1'b1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign w_beat     = w_valid & w_ready;
  assign r_beat     = r_valid & r_ready;
  assign bram_ena   = w_beat | r_beat;
  assign bram_wea   = w_beat;
  assign bram_addra = (state_q == StGntW) ? w_addr : r_addr;
  assign bram_dina  = w_data;
  assign r_dvalid   = r_dvalid_q;
  assign r_data     = bram_douta;

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state_q    <= StIdle;
      last_r_q   <= 1'b1;
      beat_cnt_q <= '0;
      r_dvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_r_q   <= last_r_d;
      beat_cnt_q <= beat_cnt_d;
      r_dvalid_q <= r_beat;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: queued write/read drivers, a BRAM model, a
// reference memory updated at handshakes, and grant-trace checks for directed scenarios.
module tb_bram_port_arbiter;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 8;
  localparam int unsigned BL = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    gap;
  } txn_t;

  logic          clka = 1'b0;
  logic          rsta_n;
  logic          w_valid, w_ready, r_valid, r_ready, r_dvalid;
  logic [AW-1:0] w_addr, r_addr, bram_addra;
  logic [DW-1:0] w_data, r_data, bram_dina, bram_douta;
  logic          bram_ena, bram_wea;

  always #5 clka = ~clka;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .BIT_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clka(clka), .rsta_n(rsta_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .r_dvalid(r_dvalid), .r_data(r_data),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
    .bram_dina(bram_dina), .bram_douta(bram_douta)
  );

  // BRAM model: registered read, write does not update douta
  logic [DW-1:0] bmem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) bmem[i] = '0;
    bram_douta = '0;
  end
  always @(posedge clka) begin
    if (bram_ena) begin
      if (bram_wea) bmem[bram_addra] <= bram_dina;
      else          bram_douta <= bmem[bram_addra];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  txn_t          wq[$], rq[$];
  logic [DW-1:0] expq[$], capq[$];
  byte           gtrace[$];
  logic [DW-1:0] ref_mem [int unsigned];
  logic          w_fire = 0, r_fire = 0, w_pend = 0, r_pend = 0;
  int            w_gap = 0, r_gap = 0;

  // Write driver: holds each transaction until accepted, optional idle gap before it
  initial begin
    txn_t t;
    w_valid = 0; w_addr = '0; w_data = '0;
    forever begin
      @(posedge clka); #1;
      if (w_valid && w_fire) w_valid = 0;
      if (!w_valid) begin
        if (w_pend) begin
          if (w_gap > 0) w_gap--;
          if (w_gap == 0) begin w_valid = 1; w_pend = 0; end
        end else if (wq.size() > 0) begin
          t = wq.pop_front();
          w_addr = t.addr; w_data = t.data; w_gap = int'(t.gap);
          if (t.gap == 0) w_valid = 1; else w_pend = 1;
        end
      end
    end
  end

  initial begin
    txn_t t;
    r_valid = 0; r_addr = '0;
    forever begin
      @(posedge clka); #1;
      if (r_valid && r_fire) r_valid = 0;
      if (!r_valid) begin
        if (r_pend) begin
          if (r_gap > 0) r_gap--;
          if (r_gap == 0) begin r_valid = 1; r_pend = 0; end
        end else if (rq.size() > 0) begin
          t = rq.pop_front();
          r_addr = t.addr; r_gap = int'(t.gap);
          if (t.gap == 0) r_valid = 1; else r_pend = 1;
        end
      end
    end
  end

  // Monitor / scoreboard, sampled mid-cycle
  logic          prev_rbeat = 0, prev_rst_n = 0;
  int            w_wait = 0, r_wait = 0;
  logic [AW-1:0] last_beat_addr = '0;

  always @(negedge clka) begin
    logic wb, rb;
    logic [DW-1:0] e;
    byte c;
    wb = w_valid & w_ready;
    rb = r_valid & r_ready;
    w_fire = wb;
    r_fire = rb;
    check("ready_excl", int'(w_ready & r_ready), 0);
    check("bram_ena", int'(bram_ena), int'(wb | rb));
    check("bram_wea", int'(bram_wea), int'(wb));
    check("dvalid_align", int'(r_dvalid), int'(prev_rbeat & prev_rst_n));
    if (r_dvalid) begin
      if (expq.size() == 0) begin
        check("unexpected_dvalid", 1, 0);
      end else begin
        e = expq.pop_front();
        check("r_data", int'(r_data), int'(e));
      end
      capq.push_back(r_data);
    end
    if (wb) begin
      check("w_addra", int'(bram_addra), int'(w_addr));
      check("w_dina", int'(bram_dina), int'(w_data));
      ref_mem[int'(w_addr)] = w_data;
      last_beat_addr = bram_addra;
      if (r_valid) begin
        w_wait++;
        check("w_burst_bound", int'(w_wait <= int'(BL)), 1);
      end
    end
    if (rb) begin
      check("r_addra", int'(bram_addra), int'(r_addr));
      last_beat_addr = bram_addra;
      // Response to a read accepted in a reset cycle is dropped
      if (rsta_n) expq.push_back(ref_mem.exists(int'(r_addr)) ? ref_mem[int'(r_addr)] : '0);
      if (w_valid) begin
        r_wait++;
        check("r_burst_bound", int'(r_wait <= int'(BL)), 1);
      end
    end
    if (rb || !rsta_n) w_wait = 0;
    if (wb || !rsta_n) r_wait = 0;
    if (w_ready)      c = wb ? "W" : "w";
    else if (r_ready) c = rb ? "R" : "r";
    else              c = "I";
    gtrace.push_back(c);
    prev_rbeat = rb;
    prev_rst_n = rsta_n;
  end

  function automatic logic busy();
    return w_valid || w_pend || (wq.size() > 0) || r_valid || r_pend || (rq.size() > 0);
  endfunction

  task automatic wait_drain(int limit);
    int k = 0;
    while ((busy() || expq.size() > 0) && k < limit) begin
      @(posedge clka);
      k++;
    end
    if (busy() || expq.size() > 0) check("drain_timeout", 1, 0);
    repeat (3) @(posedge clka);
  endtask

  task automatic wait_trace(int n);
    int k = 0;
    while (gtrace.size() < n && k < 500) begin
      @(posedge clka);
      k++;
    end
    if (gtrace.size() < n) check("trace_timeout", gtrace.size(), n);
  endtask

  task automatic cmp_trace(string name, string exp);
    wait_trace(exp.len());
    for (int i = 0; i < exp.len(); i++) begin
      if (i < gtrace.size()) check($sformatf("%s[%0d]", name, i), int'(gtrace[i]), int'(exp[i]));
    end
  endtask

  task automatic seg_reset();
    @(posedge clka); #2;
    rsta_n = 0;
    @(posedge clka); #2;
  endtask

  task automatic seg_release();
    repeat (2) @(posedge clka);
    #2;
    rsta_n = 1;
    gtrace.delete();
  endtask

  function automatic txn_t mk(int a, int d, int g);
    txn_t t;
    t.addr = AW'(a);
    t.data = DW'(d);
    t.gap  = 4'(g);
    return t;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    int p;
    rsta_n = 0;
    repeat (2) @(posedge clka);
    #2;

    // Reset with both requesters valid, then contention pattern
    for (int i = 0; i < 12; i++) begin
      wq.push_back(mk(16'h100 + i, $urandom_range(0, 255), 0));
      rq.push_back(mk(16'h100 + i, 0, 0));
    end
    repeat (2) @(posedge clka);
    @(negedge clka);
    check("rst_w_ready", int'(w_ready), 0);
    check("rst_r_ready", int'(r_ready), 0);
    check("rst_bram_ena", int'(bram_ena), 0);
    check("rst_r_dvalid", int'(r_dvalid), 0);
    @(posedge clka); #2;
    rsta_n = 1;
    gtrace.delete();
    s = "I";
    for (int k = 0; k < 29; k++) begin
      p = k % (2 * BL + 2);
      s = {s, (p < BL) ? "W" : (p == BL) ? "I" : (p < 2 * BL + 1) ? "R" : "I"};
    end
    cmp_trace("contend", s);
    wait_drain(500);

    // Write burst then readback
    seg_reset();
    for (int i = 0; i < 4; i++) wq.push_back(mk(i, 8'h10 + i, 0));
    seg_release();
    wait_drain(200);
    capq.delete();
    for (int i = 0; i < 4; i++) rq.push_back(mk(i, 0, 0));
    wait_drain(200);
    check("readback_count", capq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < capq.size()) check($sformatf("readback[%0d]", i), int'(capq[i]), 8'h10 + i);

    // Early release of W after 2 beats; counter must restart for the R grant
    seg_reset();
    wq.push_back(mk(20, 8'h21, 0));
    wq.push_back(mk(21, 8'h22, 0));
    wq.push_back(mk(22, 8'h23, 3));
    for (int i = 0; i < 5; i++) wq.push_back(mk(23 + i, 8'h30 + i, 0));
    for (int i = 0; i < 8; i++) rq.push_back(mk(20 + i, 0, 0));
    seg_release();
    cmp_trace("early", "IWWwIRRRRIWWWWIRRRRIWWwI");
    wait_drain(300);

    // Reset asserted in the cycle of a read beat
    seg_reset();
    for (int i = 0; i < 6; i++) rq.push_back(mk(i, 0, 0));
    seg_release();
    repeat (3) @(posedge clka);
    #2;
    rsta_n = 0;
    @(negedge clka);
    check("midrst_beat", int'(r_valid & r_ready), 1);
    @(negedge clka);
    check("midrst_dvalid", int'(r_dvalid), 0);
    check("midrst_r_ready", int'(r_ready), 0);
    check("midrst_w_ready", int'(w_ready), 0);
    @(posedge clka); #2;
    rsta_n = 1;
    wait_drain(300);

    // Top address, then an uncontended 10-beat write stream
    seg_reset();
    wq.push_back(mk(18'h3FFFF, 8'hA5, 0));
    seg_release();
    wait_drain(100);
    check("top_w_addra", int'(last_beat_addr), 18'h3FFFF);
    capq.delete();
    rq.push_back(mk(18'h3FFFF, 0, 0));
    wait_drain(100);
    check("top_r_addra", int'(last_beat_addr), 18'h3FFFF);
    check("top_count", capq.size(), 1);
    if (capq.size() > 0) check("top_data", int'(capq[0]), 8'hA5);

    seg_reset();
    for (int i = 0; i < 10; i++) wq.push_back(mk(40 + i, i, 0));
    seg_release();
    cmp_trace("stream", "IWWWWWWWWWWwI");
    wait_drain(200);

    // Random mixed traffic on a small address set plus the top address
    seg_reset();
    seg_release();
    for (int i = 0; i < 150; i++) begin
      wq.push_back(mk(($urandom_range(0, 9) == 0) ? 18'h3FFFF : $urandom_range(0, 15),
                      $urandom_range(0, 255),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0));
      rq.push_back(mk(($urandom_range(0, 9) == 0) ? 18'h3FFFF : $urandom_range(0, 15), 0,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0));
    end
    wait_drain(5000);
    check("final_expq_empty", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
